// File: rtl/a2_inv_state_mapper_if.sv
// Handshake bundle for the A2 inverse state mapper: input state, output state and busy flag.
interface a2_inv_state_mapper_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    // Producer/consumer side (drives requests, accepts results)
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );

    // Mapper side
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );
endinterface

// File: rtl/a2_inv_state_mapper.sv
// Sequential inverse A2 basis map over a 128-bit AES state: composite-field bytes back to
// standard GF(2^8) representation, LANES bytes per cycle, valid/ready on both sides.
module a2_inv_state_mapper #(
    parameter int unsigned LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    a2_inv_state_mapper_if.slave  bus
);
    localparam int unsigned Groups = 16 / LANES;
    localparam int unsigned CntW   = (Groups > 1) ? $clog2(Groups) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Groups - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [127:0]    work_q, work_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Inverse basis map for one byte (o = composite basis, result = standard basis)
    function automatic logic [7:0] inv_map(input logic [7:0] o);
        logic [7:0] i;
        i[7] = o[7] ^ o[5] ^ o[3] ^ o[1];
        i[6] = o[5] ^ o[3] ^ o[1];
        i[5] = o[3] ^ o[1];
        i[4] = o[7] ^ o[1];
        i[3] = o[6] ^ o[3] ^ o[1];
        i[2] = o[5] ^ o[4] ^ o[3];
        i[1] = o[3] ^ o[2] ^ o[1];
        i[0] = o[7] ^ o[5] ^ o[3] ^ o[0];
        return i;
    endfunction

    // State, work register and byte-group counter; reset discards any in-flight state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            work_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: capture in IDLE, map one byte group per BUSY cycle, hold in DONE
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    work_d  = bus.in_data;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Constant byte indices compared against cnt keep the datapath mux-free
                for (int b = 0; b < 16; b++) begin
                    if (CntW'(b / LANES) == cnt_q) begin
                        work_d[b*8 +: 8] = inv_map(work_q[b*8 +: 8]);
                    end
                end
                // Counter stops on the last group; it only restarts on a new accept
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state; out_data always mirrors the work register
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.busy      = (state_q == StBusy) || (state_q == StDone);
        bus.out_data  = work_q;
    end
endmodule
